// File: rtl/mem_sbus_responder.sv
// S-bus memory responder for a single MBox controller: acknowledges quadword cycles,
// returns read words in wrap order from the starting word and sinks write words.
module mem_sbus_responder #(
  parameter int unsigned ADR_BITS = 14,
  parameter int unsigned ACK_DLY  = 2,
  parameter int unsigned DV_DLY   = 3,
  parameter int unsigned WORD_GAP = 1
) (
  input  logic        clk1_mem_h,
  input  logic        mr_reset_h,
  input  logic        mem_start_h,
  input  logic [3:0]  mem_rq_h,
  input  logic        mem_rd_rq_h,
  input  logic        mem_wr_rq_h,
  input  logic [21:0] mem_adr_h,
  input  logic        mem_adr_par_h,
  input  logic [35:0] mem_wr_data_h,
  input  logic        mem_wr_data_valid_h,
  output logic        mem_ackn_h,
  output logic        mem_data_valid_h,
  output logic [35:0] mem_rd_data_h,
  output logic        mem_busy_h,
  output logic        adr_par_err_h
);

  localparam logic [15:0] ACK_C = 16'(ACK_DLY);
  localparam logic [15:0] DV_C  = 16'(DV_DLY);
  localparam logic [15:0] GAP_C = 16'(WORD_GAP + 1);

  typedef enum logic [2:0] {IDLE, ACKW, RDW, RDX, WRX} state_t;

  state_t               state, state_nx;
  logic [15:0]          cnt, cnt_nx;
  logic                 first, first_nx;
  logic [3:0]           pend, pend_nx;
  logic [1:0]           slot, slot_nx;
  logic                 is_rd;
  logic [ADR_BITS-3:0]  base;
  logic [1:0]           cur;
  logic [3:0]           pend_clr;
  logic [ADR_BITS-1:0]  wadr;
  logic                 par_bad, nxm, accept, ram_we;
  logic [35:0]          ram [2**ADR_BITS];

  // First still-pending slot at or after 'from', walking the quadword with wrap.
  function automatic logic [1:0] next_slot(input logic [3:0] p, input logic [1:0] from);
    logic [1:0] s;
    next_slot = from;
    for (int unsigned k = 0; k < 4; k++) begin
      s = from + 2'(3 - k);
      if (p[s]) next_slot = s;
    end
  endfunction

  assign par_bad    = ~(^{mem_adr_h, mem_adr_par_h});
  assign nxm        = (mem_adr_h >> ADR_BITS) != '0;
  assign accept     = (state == IDLE) && mem_start_h && !par_bad && !nxm &&
                      (mem_rd_rq_h != mem_wr_rq_h);
  assign mem_busy_h = (state != IDLE);
  assign cur        = next_slot(pend, slot);
  assign pend_clr   = pend & ~(4'b0001 << cur);
  assign wadr       = {base, cur};

  always_ff @(posedge clk1_mem_h) begin
    if (mr_reset_h) begin
      state         <= IDLE;
      cnt           <= '0;
      first         <= 1'b0;
      pend          <= '0;
      slot          <= '0;
      is_rd         <= 1'b0;
      base          <= '0;
      adr_par_err_h <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      first <= first_nx;
      pend  <= pend_nx;
      slot  <= slot_nx;
      if (accept) begin
        is_rd <= mem_rd_rq_h;
        base  <= mem_adr_h[ADR_BITS-1:2];
      end
      if ((state == IDLE) && mem_start_h && par_bad) adr_par_err_h <= 1'b1;
    end
  end

  always_ff @(posedge clk1_mem_h) begin
    if (ram_we && !mr_reset_h) ram[wadr] <= mem_wr_data_h;
  end

  always_comb begin
    state_nx         = state;
    cnt_nx           = cnt;
    first_nx         = first;
    pend_nx          = pend;
    slot_nx          = slot;
    mem_ackn_h       = 1'b0;
    mem_data_valid_h = 1'b0;
    ram_we           = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = ACKW;
          cnt_nx   = 16'd1;
          first_nx = 1'b1;
          pend_nx  = mem_rq_h;
          slot_nx  = mem_adr_h[1:0];
        end
      end
      ACKW: begin
        if (cnt == ACK_C) begin
          mem_ackn_h = 1'b1;
          cnt_nx     = 16'd1;
          if (pend == '0)      state_nx = IDLE;
          else if (!is_rd)     state_nx = WRX;
          else if (DV_DLY == 1) state_nx = RDX;
          else                 state_nx = RDW;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      // RDW spans the wait before a data cycle; RDX is the data cycle itself.
      RDW: begin
        if (cnt == (first ? DV_C : GAP_C) - 16'd1) state_nx = RDX;
        else cnt_nx = cnt + 16'd1;
      end
      RDX: begin
        mem_data_valid_h = 1'b1;
        pend_nx          = pend_clr;
        slot_nx          = cur + 2'd1;
        first_nx         = 1'b0;
        cnt_nx           = 16'd1;
        if (pend_clr == '0)     state_nx = IDLE;
        else if (WORD_GAP == 0) state_nx = RDX;
        else                    state_nx = RDW;
      end
      WRX: begin
        if (mem_wr_data_valid_h) begin
          ram_we  = 1'b1;
          pend_nx = pend_clr;
          slot_nx = cur + 2'd1;
          if (pend_clr == '0) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem_rd_data_h = mem_data_valid_h ? ram[wadr] : '0;

endmodule

// File: tb/tb_mem_sbus_responder.sv
// Bench for mem_sbus_responder: per-cycle expectation tables filled from the protocol
// rules, directed scenarios with literal results, then randomized transactions.
module tb_mem_sbus_responder;
  localparam int ADR_BITS = 14;
  localparam int ACK_DLY  = 2;
  localparam int DV_DLY   = 3;
  localparam int WORD_GAP = 1;
  localparam int MAXC     = 4000;

  logic        clk = 1'b0;
  logic        mr_reset_h = 1'b1;
  logic        mem_start_h = 1'b0;
  logic [3:0]  mem_rq_h = '0;
  logic        mem_rd_rq_h = 1'b0;
  logic        mem_wr_rq_h = 1'b0;
  logic [21:0] mem_adr_h = '0;
  logic        mem_adr_par_h = 1'b0;
  logic [35:0] mem_wr_data_h = '0;
  logic        mem_wr_data_valid_h = 1'b0;
  logic        mem_ackn_h, mem_data_valid_h, mem_busy_h, adr_par_err_h;
  logic [35:0] mem_rd_data_h;

  mem_sbus_responder #(.ADR_BITS(ADR_BITS), .ACK_DLY(ACK_DLY), .DV_DLY(DV_DLY),
                       .WORD_GAP(WORD_GAP)) dut (
    .clk1_mem_h(clk), .mr_reset_h(mr_reset_h), .mem_start_h(mem_start_h),
    .mem_rq_h(mem_rq_h), .mem_rd_rq_h(mem_rd_rq_h), .mem_wr_rq_h(mem_wr_rq_h),
    .mem_adr_h(mem_adr_h), .mem_adr_par_h(mem_adr_par_h), .mem_wr_data_h(mem_wr_data_h),
    .mem_wr_data_valid_h(mem_wr_data_valid_h), .mem_ackn_h(mem_ackn_h),
    .mem_data_valid_h(mem_data_valid_h), .mem_rd_data_h(mem_rd_data_h),
    .mem_busy_h(mem_busy_h), .adr_par_err_h(adr_par_err_h));

  always #5 clk = ~clk;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        exp_ackn [MAXC];
  logic        exp_dv   [MAXC];
  logic        exp_busy [MAXC];
  logic        exp_perr [MAXC];
  logic [35:0] exp_data [MAXC];
  logic [35:0] mem_m [int];
  int          ack_q[$];
  int          dv_q[$];
  logic [35:0] dvd_q[$];
  logic [35:0] wd_none [4] = '{default: '0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      chk("ackn",    36'(mem_ackn_h),       36'(exp_ackn[cyc]));
      chk("dvalid",  36'(mem_data_valid_h), 36'(exp_dv[cyc]));
      chk("rd_data", mem_rd_data_h,         exp_data[cyc]);
      chk("busy",    36'(mem_busy_h),       36'(exp_busy[cyc]));
      chk("par_err", 36'(adr_par_err_h),    36'(exp_perr[cyc]));
      if (mem_ackn_h) ack_q.push_back(cyc);
      if (mem_data_valid_h) begin
        dv_q.push_back(cyc);
        dvd_q.push_back(mem_rd_data_h);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] rnd36();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[35:0];
  endfunction

  task automatic clear_q();
    ack_q.delete();
    dv_q.delete();
    dvd_q.delete();
  endtask

  // Reset asserted during the current cycle; outputs are quiet from the next one.
  task automatic do_reset();
    for (int c = cyc + 1; c < MAXC; c++) begin
      exp_ackn[c] = 1'b0; exp_dv[c] = 1'b0; exp_busy[c] = 1'b0;
      exp_perr[c] = 1'b0; exp_data[c] = '0;
    end
    mr_reset_h = 1'b1;
    tick();
    mr_reset_h = 1'b0;
  endtask

  task automatic txn(input bit rd, input bit wr, input logic [21:0] adr, input logic [3:0] rq,
                     input bit bad_par, input bit poke, input bit abort,
                     input bit use_wd, input logic [35:0] wd [4], output int n);
    int a, last, k, v0;
    bit ok;
    logic [1:0] w;
    logic [35:0] d;
    n = cyc;
    mem_start_h = 1'b1; mem_rd_rq_h = rd; mem_wr_rq_h = wr; mem_rq_h = rq;
    mem_adr_h = adr; mem_adr_par_h = (~(^adr)) ^ bad_par; mem_wr_data_valid_h = 1'b0;
    ok = !bad_par && ((adr >> ADR_BITS) == 0) && (rd != wr);
    if (bad_par) for (int c = n + 1; c < MAXC; c++) exp_perr[c] = 1'b1;
    tick();
    mem_start_h = 1'b0; mem_rq_h = 4'($urandom); mem_adr_h = 22'($urandom);
    mem_rd_rq_h = 1'($urandom); mem_wr_rq_h = 1'($urandom); mem_adr_par_h = 1'($urandom);
    if (!ok) begin
      repeat (2) tick();
      return;
    end
    a = n + ACK_DLY;
    exp_ackn[a] = 1'b1;
    if (rd || rq == 4'b0000) begin
      last = a; k = 0; v0 = 0;
      for (int i = 0; i < 4; i++) begin
        w = adr[1:0] + 2'(i);
        if (rq[w]) begin
          last = a + DV_DLY + k * (WORD_GAP + 1);
          if (k == 0) v0 = last;
          exp_dv[last] = 1'b1;
          exp_data[last] = mem_m[int'({adr[21:2], w})];
          k++;
        end
      end
      for (int c = n + 1; c <= last; c++) exp_busy[c] = 1'b1;
      if (abort && k > 0) begin
        while (cyc < v0 + 1) tick();
        do_reset();
        tick();
        return;
      end
      if (poke && k > 0) begin
        while (cyc < a + 1) tick();
        mem_start_h = 1'b1; mem_rd_rq_h = 1'b0; mem_wr_rq_h = 1'b1; mem_rq_h = 4'hF;
        mem_adr_h = 22'h300; mem_adr_par_h = ~(^mem_adr_h);
        tick();
        mem_start_h = 1'b0;
      end
      while (cyc <= last) tick();
    end else begin
      for (int c = n + 1; c <= a; c++) exp_busy[c] = 1'b1;
      while (cyc < a) tick();
      mem_wr_data_valid_h = 1'b1; mem_wr_data_h = rnd36();
      tick();
      k = 0;
      for (int i = 0; i < 4; i++) begin
        w = adr[1:0] + 2'(i);
        if (rq[w]) begin
          repeat ($urandom_range(0, 2)) begin
            mem_wr_data_valid_h = 1'b0; mem_wr_data_h = rnd36(); exp_busy[cyc] = 1'b1;
            tick();
          end
          d = use_wd ? wd[k] : rnd36();
          mem_wr_data_valid_h = 1'b1; mem_wr_data_h = d; exp_busy[cyc] = 1'b1;
          mem_m[int'({adr[21:2], w})] = d;
          k++;
          tick();
        end
      end
      mem_wr_data_valid_h = 1'b0;
      tick();
    end
  endtask

  initial begin
    int n;
    int offs [4] = '{5, 7, 9, 11};
    logic [35:0] vals [4];
    logic [35:0] wd [4];
    logic [21:0] ra;
    int kind;

    for (int c = 0; c < MAXC; c++) begin
      exp_ackn[c] = 1'b0; exp_dv[c] = 1'b0; exp_busy[c] = 1'b0;
      exp_perr[c] = 1'b0; exp_data[c] = '0;
    end
    repeat (3) tick();
    mr_reset_h = 1'b0;
    tick();
    chk("reset_busy", 36'(mem_busy_h), 36'd0);

    wd = '{36'd1, 36'd2, 36'd3, 36'd4};
    txn(0, 1, 22'h100, 4'hF, 0, 0, 0, 1, wd, n);
    wd = '{36'h111, 36'h222, 36'h333, 36'h444};
    txn(0, 1, 22'h200, 4'hF, 0, 0, 0, 1, wd, n);

    clear_q();
    txn(1, 0, 22'h102, 4'hF, 0, 0, 0, 0, wd_none, n);
    vals = '{36'd3, 36'd4, 36'd1, 36'd2};
    chk("quad_ack_count", 36'(ack_q.size()), 36'd1);
    chk("quad_ack_ofs", 36'(ack_q[0] - n), 36'd2);
    chk("quad_dv_count", 36'(dv_q.size()), 36'd4);
    for (int i = 0; i < 4; i++) begin
      chk("quad_dv_ofs", 36'(dv_q[i] - n), 36'(offs[i]));
      chk("quad_data", dvd_q[i], vals[i]);
    end

    wd = '{36'hA_AAAA_AAAA, 36'hB_BBBB_BBBB, 36'h0, 36'h0};
    txn(0, 1, 22'h201, 4'b0101, 0, 0, 0, 1, wd, n);
    clear_q();
    txn(1, 0, 22'h200, 4'hF, 0, 0, 0, 0, wd_none, n);
    vals = '{36'hB_BBBB_BBBB, 36'h222, 36'hA_AAAA_AAAA, 36'h444};
    for (int i = 0; i < 4; i++) chk("sparse_data", dvd_q[i], vals[i]);

    clear_q();
    txn(1, 0, 22'h100, 4'hF, 1, 0, 0, 0, wd_none, n);
    chk("par_flag_set", 36'(adr_par_err_h), 36'd1);
    chk("par_no_ack", 36'(ack_q.size()), 36'd0);
    txn(1, 0, 22'h100, 4'b0001, 0, 0, 0, 0, wd_none, n);
    chk("par_next_ack", 36'(ack_q.size()), 36'd1);
    chk("par_next_data", dvd_q[0], 36'd1);
    do_reset();
    tick();
    chk("par_flag_clr", 36'(adr_par_err_h), 36'd0);

    clear_q();
    txn(1, 0, 22'h4100, 4'hF, 0, 0, 0, 0, wd_none, n);
    chk("nxm_no_ack", 36'(ack_q.size()), 36'd0);
    chk("nxm_no_flag", 36'(adr_par_err_h), 36'd0);

    clear_q();
    txn(1, 0, 22'h100, 4'hF, 0, 1, 0, 0, wd_none, n);
    chk("poke_ack_count", 36'(ack_q.size()), 36'd1);
    chk("poke_dv_count", 36'(dv_q.size()), 36'd4);
    clear_q();
    txn(1, 0, 22'h100, 4'h0, 0, 0, 0, 0, wd_none, n);
    chk("rq0_ack_count", 36'(ack_q.size()), 36'd1);
    chk("rq0_dv_count", 36'(dv_q.size()), 36'd0);

    clear_q();
    txn(1, 0, 22'h102, 4'hF, 0, 0, 1, 0, wd_none, n);
    chk("abort_dv_count", 36'(dv_q.size()), 36'd1);
    chk("abort_data", dvd_q[0], 36'd3);
    clear_q();
    txn(1, 0, 22'h100, 4'hF, 0, 0, 0, 0, wd_none, n);
    vals = '{36'd1, 36'd2, 36'd3, 36'd4};
    for (int i = 0; i < 4; i++) chk("after_abort_data", dvd_q[i], vals[i]);

    for (int q = 0; q < 16; q++)
      txn(0, 1, 22'(q * 4), 4'hF, 0, 0, 0, 0, wd_none, n);

    for (int it = 0; it < 60 && cyc < MAXC - 200; it++) begin
      kind = $urandom_range(0, 9);
      ra = 22'($urandom_range(0, 63));
      case (kind)
        0: txn(1, 0, ra, 4'($urandom), 1, 0, 0, 0, wd_none, n);
        1: txn(1, 0, ra | (22'd1 << $urandom_range(14, 21)), 4'hF, 0, 0, 0, 0, wd_none, n);
        2: begin
          if ($urandom_range(0, 1) == 1) txn(1, 1, ra, 4'hF, 0, 0, 0, 0, wd_none, n);
          else txn(0, 0, ra, 4'hF, 0, 0, 0, 0, wd_none, n);
        end
        3, 4, 5, 6: txn(1, 0, ra, 4'($urandom), 0, $urandom_range(0, 3) == 0, 0, 0, wd_none, n);
        default: txn(0, 1, ra, 4'($urandom), 0, 0, 0, 0, wd_none, n);
      endcase
      repeat ($urandom_range(1, 3)) begin
        mem_wr_data_valid_h = 1'($urandom); mem_wr_data_h = rnd36();
        tick();
      end
      mem_wr_data_valid_h = 1'b0;
    end

    do_reset();
    tick();
    chk("final_par_clr", 36'(adr_par_err_h), 36'd0);
    chk("final_idle", 36'(mem_busy_h), 36'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
